chi_sched: RTL and testbench
============================

CHI_SCHED -- requirements
Module: chi_sched

Interface
REQ-001 SHALL have parameter PARAMETERBITS, default 14, giving the chi-square word width.
REQ-002 SHALL have parameter IDXBITS, default 8, giving the fit-index width.
REQ-003 SHALL have parameter CHICUT, default 2^PARAMETERBITS-2, giving the largest accepted chi-square.
REQ-004 SHALL have port CLOCK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port DIN_VALID, input, 1 bit: chi-square word offered.
REQ-007 SHALL have port DIN_CHI, input, PARAMETERBITS bits: chi-square of one fit candidate.
REQ-008 SHALL have port DIN_LAST, input, 1 bit: marks the last word of an event; qualified by DIN_VALID.
REQ-009 SHALL have port DIN_READY, output, 1 bit: block accepts a word this cycle.
REQ-010 SHALL have port CHI_CE, output, 1 bit: load strobe for the downstream chi register, pulsed when a new minimum is captured.
REQ-011 SHALL have port DOUT_VALID, output, 1 bit: event result available.
REQ-012 SHALL have port DOUT_READY, input, 1 bit: consumer takes the result.
REQ-013 SHALL have port DOUT_CHI, output, PARAMETERBITS bits: minimum accepted chi-square.
REQ-014 SHALL have port DOUT_IDX, output, IDXBITS bits: index of the minimum within the event.
REQ-015 SHALL have port DOUT_NPASS, output, IDXBITS bits: count of words with chi <= CHICUT.
REQ-016 SHALL have port DOUT_FOUND, output, 1 bit: at least one word passed the cut.
REQ-017 SHALL have port DOUT_OVF, output, 1 bit: the event exceeded 2^IDXBITS words.

Function
REQ-018 SHALL treat a word as accepted only when DIN_VALID and DIN_READY are both 1 on a rising edge.
REQ-019 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-020 In IDLE, DIN_READY SHALL be 1; an accepted word SHALL start an event at index 0 and move the FSM to ACCUM, or to HOLD if DIN_LAST=1.
REQ-021 In ACCUM, DIN_READY SHALL be 1; an accepted word with DIN_LAST=1 SHALL move the FSM to HOLD.
REQ-022 In HOLD, DIN_READY SHALL be 0 and DOUT_VALID 1; DOUT_VALID and DOUT_READY both 1 SHALL move the FSM to IDLE.
REQ-023 DOUT_VALID SHALL rise the cycle after the DIN_LAST word is accepted (latency 1).
REQ-024 DOUT_* SHALL be registered and SHALL stay stable throughout HOLD.
REQ-025 The word index SHALL increment per accepted word and saturate at 2^IDXBITS-1; on a further word DOUT_OVF SHALL be set and remain set until the event's result is consumed.
REQ-026 A word SHALL become the new minimum only if its chi <= CHICUT and its chi < the current minimum (strict comparison); on a tie the earlier index is kept.
REQ-027 When a new minimum is captured, CHI_CE SHALL pulse high for exactly that acceptance cycle.
REQ-028 DOUT_NPASS SHALL count passing words and saturate at 2^IDXBITS-1.
REQ-029 An event with no passing word SHALL report DOUT_FOUND=0, DOUT_CHI all ones, DOUT_IDX=0 and DOUT_NPASS=0.
REQ-030 Per-event state (minimum, index, count, overflow flag) SHALL be re-initialised when each event's first word is accepted.

Reset
REQ-031 Asserting RESET_N=0 SHALL immediately force IDLE, DIN_READY=1, CHI_CE=0, DOUT_VALID=0, DOUT_CHI all ones, and DOUT_IDX, DOUT_NPASS, DOUT_FOUND and DOUT_OVF to 0.
REQ-032 A reset asserted mid-event or during HOLD SHALL discard the partial or pending result without emitting it.

Structure
REQ-033 The FSM state encoding and the all-ones chi constant SHALL live in a shared package, gf_chi_pkg.
REQ-034 The minimum/compare register with its capture enable SHALL be a single sub-module, chi_min_reg; the FSM, counters and handshake SHALL stay in chi_sched.

Verification
REQ-035 Bench SHALL drive chi 100, 40 and 40(LAST) and require DOUT_CHI=40, DOUT_IDX=1, DOUT_NPASS=3, DOUT_FOUND=1, with CHI_CE pulsed exactly twice.
REQ-036 Bench SHALL drive a single word, chi 16383 with LAST, and require DOUT_FOUND=0, DOUT_CHI=16383, DOUT_NPASS=0.
REQ-037 Bench SHALL send 300 words (IDXBITS=8), minimum at word 5, and require DOUT_IDX=5, DOUT_OVF=1, DOUT_NPASS=255.
REQ-038 Bench SHALL hold DOUT_READY=0 for 10 cycles during HOLD and require DIN_READY=0 and DOUT_* stable; a new event SHALL then be accepted the cycle after the handshake.
REQ-039 Bench SHALL assert RESET_N low after the 2nd of 4 words and require no DOUT_VALID pulse, with all outputs at their reset values.
REQ-040 Bench SHALL send two back-to-back events with chi 7(LAST) then 9(LAST) and require results 7/idx0 then 9/idx0, with no carry-over between events.

Source files
------------

// File: rtl/gf_chi_pkg.sv
// Shared types and constants for the chi-square minimum scheduler.
// Holds the FSM state encoding and the all-ones "no result" chi word.
package gf_chi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } chi_state_e;

   // Sliced to the chi width by each user; widths up to 32 bits.
   localparam logic [31:0] CHI_ONES = '1;

endpackage

// File: rtl/chi_sched_if.sv
// Word-in / result-out bundle of the chi-square minimum scheduler.
// Signal names match the chi_sched top-level ports one to one.
interface chi_sched_if #(
   parameter int PARAMETERBITS = 14,
   parameter int IDXBITS       = 8
);

   logic                     DIN_VALID;
   logic [PARAMETERBITS-1:0] DIN_CHI;
   logic                     DIN_LAST;
   logic                     DIN_READY;
   logic                     CHI_CE;
   logic                     DOUT_VALID;
   logic                     DOUT_READY;
   logic [PARAMETERBITS-1:0] DOUT_CHI;
   logic [IDXBITS-1:0]       DOUT_IDX;
   logic [IDXBITS-1:0]       DOUT_NPASS;
   logic                     DOUT_FOUND;
   logic                     DOUT_OVF;

   modport master (
      output DIN_VALID, DIN_CHI, DIN_LAST, DOUT_READY,
      input  DIN_READY, CHI_CE, DOUT_VALID,
      input  DOUT_CHI, DOUT_IDX, DOUT_NPASS,
      input  DOUT_FOUND, DOUT_OVF
   );

   modport slave (
      input  DIN_VALID, DIN_CHI, DIN_LAST, DOUT_READY,
      output DIN_READY, CHI_CE, DOUT_VALID,
      output DOUT_CHI, DOUT_IDX, DOUT_NPASS,
      output DOUT_FOUND, DOUT_OVF
   );

endinterface

// File: rtl/chi_min_reg.sv
// Running-minimum register: keeps the smallest passing chi and its index.
// Strict less-than keeps the earliest index on ties.
module chi_min_reg
   import gf_chi_pkg::*;
#(
   parameter int PARAMETERBITS = 14,
   parameter int IDXBITS       = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     init_i,
   input  logic                     pass_i,
   input  logic [PARAMETERBITS-1:0] chi_i,
   input  logic [IDXBITS-1:0]       idx_i,
   output logic                     ce_o,
   output logic [PARAMETERBITS-1:0] chi_o,
   output logic [IDXBITS-1:0]       idx_o,
   output logic                     found_o
);

   localparam logic [PARAMETERBITS-1:0] ONES =
      CHI_ONES[PARAMETERBITS-1:0];

   logic [PARAMETERBITS-1:0] chi_q;
   logic [IDXBITS-1:0]       idx_q;
   logic                     found_q;

   // First word of an event ignores the stale minimum from the last event.
   assign ce_o = en_i & pass_i & (init_i | (chi_i < chi_q));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chi_q   <= ONES;
         idx_q   <= '0;
         found_q <= 1'b0;
      end else if (ce_o) begin
         chi_q   <= chi_i;
         idx_q   <= idx_i;
         found_q <= 1'b1;
      end else if (en_i && init_i) begin
         chi_q   <= ONES;
         idx_q   <= '0;
         found_q <= 1'b0;
      end
   end

   assign chi_o   = chi_q;
   assign idx_o   = idx_q;
   assign found_o = found_q;

endmodule

// File: rtl/chi_sched.sv
// Chi-square minimum scheduler: scans an event's words, reports the best fit.
// FSM, index/pass counters and handshakes; the minimum lives in chi_min_reg.
module chi_sched
   import gf_chi_pkg::*;
#(
   parameter int PARAMETERBITS = 14,
   parameter int IDXBITS       = 8,
   parameter int CHICUT        = (1 << PARAMETERBITS) - 2
) (
   input  logic                     CLOCK,
   input  logic                     RESET_N,
   input  logic                     DIN_VALID,
   input  logic [PARAMETERBITS-1:0] DIN_CHI,
   input  logic                     DIN_LAST,
   output logic                     DIN_READY,
   output logic                     CHI_CE,
   output logic                     DOUT_VALID,
   input  logic                     DOUT_READY,
   output logic [PARAMETERBITS-1:0] DOUT_CHI,
   output logic [IDXBITS-1:0]       DOUT_IDX,
   output logic [IDXBITS-1:0]       DOUT_NPASS,
   output logic                     DOUT_FOUND,
   output logic                     DOUT_OVF
);

   localparam logic [31:0] CUT32 = CHICUT;
   localparam logic [PARAMETERBITS-1:0] CUT = CUT32[PARAMETERBITS-1:0];
   localparam logic [IDXBITS-1:0] IDX_MAX = '1;
   localparam logic [IDXBITS-1:0] IDX_ONE = IDXBITS'(1);

   chi_state_e         state_q, state_d;
   logic [IDXBITS-1:0] idx_q, idx_d;
   logic [IDXBITS-1:0] npass_q, npass_d;
   logic               ovf_q, ovf_d;

   logic accept;
   logic first;
   logic pass;
   logic ce;

   assign DIN_READY  = (state_q != ST_HOLD);
   assign DOUT_VALID = (state_q == ST_HOLD);

   assign accept = DIN_VALID & DIN_READY;
   assign first  = accept & (state_q == ST_IDLE);
   assign pass   = (DIN_CHI <= CUT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = DIN_LAST ? ST_HOLD : ST_ACCUM;
         end
         ST_ACCUM: begin
            if (accept && DIN_LAST) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (DOUT_READY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // idx_d is the index of the word being accepted this cycle.
   always_comb begin
      idx_d   = idx_q;
      npass_d = npass_q;
      ovf_d   = ovf_q;
      if (first) begin
         idx_d   = '0;
         npass_d = pass ? IDX_ONE : '0;
         ovf_d   = 1'b0;
      end else if (accept) begin
         if (idx_q == IDX_MAX) ovf_d = 1'b1;
         else                  idx_d = idx_q + IDX_ONE;
         if (pass && (npass_q != IDX_MAX)) npass_d = npass_q + IDX_ONE;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         npass_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         npass_q <= npass_d;
         ovf_q   <= ovf_d;
      end
   end

   chi_min_reg #(
      .PARAMETERBITS (PARAMETERBITS),
      .IDXBITS       (IDXBITS)
   ) u_min (
      .clk_i   (CLOCK),
      .rst_ni  (RESET_N),
      .en_i    (accept),
      .init_i  (first),
      .pass_i  (pass),
      .chi_i   (DIN_CHI),
      .idx_i   (idx_d),
      .ce_o    (ce),
      .chi_o   (DOUT_CHI),
      .idx_o   (DOUT_IDX),
      .found_o (DOUT_FOUND)
   );

   // Strobe is held off while reset is asserted even if a word is offered.
   assign CHI_CE     = ce & RESET_N;
   assign DOUT_NPASS = npass_q;
   assign DOUT_OVF   = ovf_q;

endmodule

// File: tb/tb_chi_sched.sv
// Randomized self-checking bench for chi_sched against an event-level model.
// Each event's words are scored in a queue; results compared in HOLD.
module tb_chi_sched;

   localparam int PB   = 14;
   localparam int IB   = 8;
   localparam int CUT  = (1 << PB) - 2;
   localparam int IMAX = (1 << IB) - 1;
   localparam int ONES = (1 << PB) - 1;

   bit clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   int ce_seen = 0;

   always #5 clk = ~clk;

   chi_sched_if #(.PARAMETERBITS(PB), .IDXBITS(IB)) bus ();

   chi_sched #(.PARAMETERBITS(PB), .IDXBITS(IB)) dut (
      .CLOCK      (clk),
      .RESET_N    (rst_n),
      .DIN_VALID  (bus.DIN_VALID),
      .DIN_CHI    (bus.DIN_CHI),
      .DIN_LAST   (bus.DIN_LAST),
      .DIN_READY  (bus.DIN_READY),
      .CHI_CE     (bus.CHI_CE),
      .DOUT_VALID (bus.DOUT_VALID),
      .DOUT_READY (bus.DOUT_READY),
      .DOUT_CHI   (bus.DOUT_CHI),
      .DOUT_IDX   (bus.DOUT_IDX),
      .DOUT_NPASS (bus.DOUT_NPASS),
      .DOUT_FOUND (bus.DOUT_FOUND),
      .DOUT_OVF   (bus.DOUT_OVF)
   );

   // Event-level reference: scan words in order, keep first smallest passing.
   task automatic model(input int w[$], output int m_chi, output int m_idx,
                        output int m_np, output int m_found,
                        output int m_ovf, output int m_ce);
      m_chi = ONES; m_idx = 0; m_np = 0; m_found = 0; m_ce = 0;
      m_ovf = (w.size() > (1 << IB)) ? 1 : 0;
      foreach (w[k]) begin
         if (w[k] <= CUT) begin
            m_np = (m_np < IMAX) ? m_np + 1 : IMAX;
            if (m_found == 0 || w[k] < m_chi) begin
               m_chi = w[k];
               m_idx = (k < IMAX) ? k : IMAX;
               m_found = 1;
               m_ce++;
            end
         end
      end
   endtask

   // Starts and ends just after a falling edge; sends the first n words.
   task automatic send(input int w[$], input int n, input bit gaps);
      logic [31:0] v;
      ce_seen = 0;
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.DIN_VALID = 1'b0;
               @(posedge clk); @(negedge clk);
            end
         end
         v = w[k];
         bus.DIN_VALID = 1'b1;
         bus.DIN_CHI   = v[PB-1:0];
         bus.DIN_LAST  = (k == w.size() - 1);
         #1;
         checks++;
         if (bus.DIN_READY !== 1'b1) begin
            errors++;
            $display("FAIL din_ready word %0d: got %b want 1", k, bus.DIN_READY);
         end
         if (bus.CHI_CE === 1'b1) ce_seen++;
         @(posedge clk); @(negedge clk);
      end
      bus.DIN_VALID = 1'b0;
      bus.DIN_LAST  = 1'b0;
   endtask

   // Called just after the falling edge following the LAST word.
   task automatic collect(input int w[$], input int hold, input string tag);
      int m_chi, m_idx, m_np, m_found, m_ovf, m_ce;
      logic [31:0] c, i, p;
      logic [PB+2*IB+2:0] exp_v, got_v;
      model(w, m_chi, m_idx, m_np, m_found, m_ovf, m_ce);
      c = m_chi; i = m_idx; p = m_np;
      exp_v = {1'b1, c[PB-1:0], i[IB-1:0], p[IB-1:0],
               m_found[0], m_ovf[0]};
      checks++;
      if (ce_seen != m_ce) begin
         errors++;
         $display("FAIL %s chi_ce count: got %0d want %0d", tag, ce_seen, m_ce);
      end
      for (int h = 0; h <= hold; h++) begin
         #1;
         got_v = {bus.DOUT_VALID, bus.DOUT_CHI, bus.DOUT_IDX,
                  bus.DOUT_NPASS, bus.DOUT_FOUND, bus.DOUT_OVF};
         checks++;
         if (got_v !== exp_v || bus.DIN_READY !== 1'b0) begin
            errors++;
            $display("FAIL %s result cyc %0d: got %h rdy %b want %h rdy 0",
                     tag, h, got_v, bus.DIN_READY, exp_v);
         end
         if (h < hold) begin
            @(posedge clk); @(negedge clk);
         end
      end
      bus.DOUT_READY = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.DOUT_READY = 1'b0;
      #1;
      checks++;
      if (bus.DOUT_VALID !== 1'b0 || bus.DIN_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s release: got valid %b rdy %b want 0 1",
                  tag, bus.DOUT_VALID, bus.DIN_READY);
      end
   endtask

   task automatic test_reset();
      logic [PB+2*IB+3:0] exp_v, got_v;
      exp_v = {1'b1, 1'b0, 1'b0, PB'(ONES), IB'(0), IB'(0), 1'b0, 1'b0};
      rst_n = 1'b0;
      bus.DIN_VALID = 1'b1;
      bus.DIN_CHI = PB'(5);
      bus.DIN_LAST = 1'b1;
      bus.DOUT_READY = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      got_v = {bus.DIN_READY, bus.CHI_CE, bus.DOUT_VALID, bus.DOUT_CHI,
               bus.DOUT_IDX, bus.DOUT_NPASS, bus.DOUT_FOUND, bus.DOUT_OVF};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL reset values: got %h want %h", got_v, exp_v);
      end
      @(negedge clk);
      bus.DIN_VALID = 1'b0;
      bus.DIN_LAST = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int w[$] = '{100, 40, 40};
      send(w, 3, 1'b0);
      collect(w, 0, "basic");
   endtask

   task automatic test_nopass();
      int w[$] = '{ONES};
      send(w, 1, 1'b0);
      collect(w, 0, "nopass");
   endtask

   task automatic test_overflow();
      int w[$];
      for (int k = 0; k < 300; k++)
         w.push_back((k == 5) ? 50 : int'($urandom_range(100, 16000)));
      send(w, 300, 1'b0);
      collect(w, 0, "overflow");
   endtask

   task automatic test_hold();
      int a[$] = '{300, 12, 900, 12, 77};
      int b[$] = '{7};
      send(a, a.size(), 1'b1);
      collect(a, 10, "hold");
      send(b, 1, 1'b0);
      collect(b, 0, "after_hold");
   endtask

   task automatic test_reset_mid();
      int w[$] = '{30, 20, 10, 5};
      int h[$] = '{3};
      logic [PB+2*IB+3:0] exp_v, got_v;
      exp_v = {1'b1, 1'b0, 1'b0, PB'(ONES), IB'(0), IB'(0), 1'b0, 1'b0};
      for (int r = 0; r < 2; r++) begin
         if (r == 0) send(w, 2, 1'b0);
         else        send(h, 1, 1'b0);
         rst_n = 1'b0;
         #1;
         got_v = {bus.DIN_READY, bus.CHI_CE, bus.DOUT_VALID, bus.DOUT_CHI,
                  bus.DOUT_IDX, bus.DOUT_NPASS, bus.DOUT_FOUND, bus.DOUT_OVF};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_reset %0d values: got %h want %h", r, got_v, exp_v);
         end
         @(negedge clk);
         rst_n = 1'b1;
         repeat (6) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (bus.DOUT_VALID !== 1'b0) begin
               errors++;
               $display("FAIL mid_reset %0d dout_valid: got %b want 0",
                        r, bus.DOUT_VALID);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int a[$] = '{7};
      int b[$] = '{9};
      send(a, 1, 1'b0);
      collect(a, 0, "b2b_first");
      send(b, 1, 1'b0);
      collect(b, 0, "b2b_second");
   endtask

   task automatic test_random();
      int w[$];
      int n;
      for (int e = 0; e < 25; e++) begin
         w.delete();
         n = $urandom_range(1, 20);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0)
               w.push_back(int'($urandom_range(CUT - 2, ONES)));
            else
               w.push_back(int'($urandom_range(0, 63)));
         end
         send(w, n, 1'b1);
         collect(w, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_nopass();
      test_overflow();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
